// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: decode/redirect/hold inputs and
// the stall, squash and forwarding controls back to the pipeline.
interface hazard_ctrl_if;
    logic [31:0] dec_inst;
    logic        ex_redirect;
    logic        ext_hold;
    logic        pc_hold;
    logic        e_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        dfwd_a;
    logic        dfwd_b;
    logic        freeze;
    logic [15:0] bubble_cnt;

    modport master (
        output dec_inst, ex_redirect, ext_hold,
        input  pc_hold, e_bubble, fwd_a, fwd_b, dfwd_a, dfwd_b, freeze, bubble_cnt
    );

    modport slave (
        input  dec_inst, ex_redirect, ext_hold,
        output pc_hold, e_bubble, fwd_a, fwd_b, dfwd_a, dfwd_b, freeze, bubble_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipeline: tracks rd metadata
// for E/M/W, generates forwarding selects, load-use stalls, redirect
// squash bubbles and the external-wait freeze.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic   clk,
    input  logic   rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] bubble_cnt_q;

    logic [4:0]  e_rd_q, e_rs1_q, e_rs2_q, m_rd_q, w_rd_q;
    logic        e_wen_q, e_load_q, e_use1_q, e_use2_q;
    logic        m_wen_q, m_load_q, w_wen_q;

    logic [6:0]  d_opc;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic        d_use1, d_use2, d_wr, d_load, d_wen;
    logic        advance, load_use, squash;
    logic        unused_bits;

    assign d_opc = bus.dec_inst[6:0];
    assign d_rd  = bus.dec_inst[11:7];
    assign d_rs1 = bus.dec_inst[19:15];
    assign d_rs2 = bus.dec_inst[24:20];
    assign d_wen = d_wr && (d_rd != 5'd0);
    assign unused_bits = ^{bus.dec_inst[31:25], bus.dec_inst[14:12]};

    // Opcode classification of the instruction in D
    always_comb begin
        d_use1 = 1'b0;
        d_use2 = 1'b0;
        d_wr   = 1'b0;
        d_load = 1'b0;
        case (d_opc)
            7'b0110011: begin d_use1 = 1'b1; d_use2 = 1'b1; d_wr = 1'b1; end
            7'b0010011: begin d_use1 = 1'b1; d_wr = 1'b1; end
            7'b0000011: begin d_use1 = 1'b1; d_wr = 1'b1; d_load = 1'b1; end
            7'b0100011: begin d_use1 = 1'b1; d_use2 = 1'b1; end
            7'b1100011: begin d_use1 = 1'b1; d_use2 = 1'b1; end
            7'b1100111: begin d_use1 = 1'b1; d_wr = 1'b1; end
            7'b1101111,
            7'b0110111,
            7'b0010111: d_wr = 1'b1;
            default: ;
        endcase
    end

    // FSM next state plus stall/squash/forward outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus.pc_hold  = 1'b0;
        bus.e_bubble = 1'b0;
        bus.freeze   = bus.ext_hold;
        advance      = !bus.ext_hold;
        squash       = 1'b0;
        load_use     = (state_q == ST_RUN) && !bus.ex_redirect && e_load_q && e_wen_q &&
                       (((e_rd_q == d_rs1) && d_use1) || ((e_rd_q == d_rs2) && d_use2));

        if (advance) begin
            squash       = bus.ex_redirect || (state_q == ST_FLUSH);
            bus.e_bubble = squash || load_use;
            bus.pc_hold  = load_use;
            if (bus.ex_redirect) begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_RELOAD;
                end
            end else if (state_q == ST_FLUSH) begin
                if (cnt_q == 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        end else begin
            bus.pc_hold = 1'b1;
        end

        if (m_wen_q && !m_load_q && (m_rd_q == e_rs1_q) && e_use1_q) bus.fwd_a = 2'b01;
        else if (w_wen_q && (w_rd_q == e_rs1_q))                     bus.fwd_a = 2'b10;
        else                                                          bus.fwd_a = 2'b00;

        if (m_wen_q && !m_load_q && (m_rd_q == e_rs2_q) && e_use2_q) bus.fwd_b = 2'b01;
        else if (w_wen_q && (w_rd_q == e_rs2_q))                     bus.fwd_b = 2'b10;
        else                                                          bus.fwd_b = 2'b00;

        bus.dfwd_a = w_wen_q && (w_rd_q == d_rs1) && d_use1 && !squash;
        bus.dfwd_b = w_wen_q && (w_rd_q == d_rs2) && d_use2 && !squash;
    end

    assign bus.bubble_cnt = bubble_cnt_q;

    // State, stage metadata and bubble counter; all hold while frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            bubble_cnt_q <= '0;
            e_rd_q <= '0; e_rs1_q <= '0; e_rs2_q <= '0;
            e_wen_q <= 1'b0; e_load_q <= 1'b0; e_use1_q <= 1'b0; e_use2_q <= 1'b0;
            m_rd_q <= '0; m_wen_q <= 1'b0; m_load_q <= 1'b0;
            w_rd_q <= '0; w_wen_q <= 1'b0;
        end else if (advance) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.e_bubble && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            if (bus.e_bubble) begin
                e_rd_q <= '0; e_rs1_q <= '0; e_rs2_q <= '0;
                e_wen_q <= 1'b0; e_load_q <= 1'b0; e_use1_q <= 1'b0; e_use2_q <= 1'b0;
            end else begin
                e_rd_q   <= d_rd;
                e_rs1_q  <= d_rs1;
                e_rs2_q  <= d_rs2;
                e_wen_q  <= d_wen;
                e_load_q <= d_load;
                e_use1_q <= d_use1;
                e_use2_q <= d_use2;
            end
            m_rd_q   <= e_rd_q;
            m_wen_q  <= e_wen_q;
            m_load_q <= e_load_q;
            w_rd_q   <= m_rd_q;
            w_wen_q  <= m_wen_q;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against an
// instruction-level model of the E/M/W pipeline slots.
module tb_hazard_ctrl;
    localparam int unsigned FC = 3;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [4:0] rd, rs1, rs2;
        logic       wen, ld, u1, u2;
    } meta_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    hazard_ctrl_if hif();

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    meta_t       mdl_e, mdl_m, mdl_w;
    int unsigned sq_left;
    int unsigned mdl_bcnt;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'h0, rd, op};
    endfunction

    function automatic meta_t decode(input logic [31:0] inst);
        meta_t r;
        logic [6:0] op;
        op    = inst[6:0];
        r.rd  = inst[11:7];
        r.rs1 = inst[19:15];
        r.rs2 = inst[24:20];
        r.u1  = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JR};
        r.u2  = op inside {OP_R, OP_ST, OP_BR};
        r.ld  = (op == OP_LD);
        r.wen = (op inside {OP_R, OP_I, OP_LD, OP_JR, OP_JAL, OP_LUI, OP_AUI}) && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic used);
        if (mdl_m.wen && !mdl_m.ld && mdl_m.rd == rs && used) return 2'b01;
        if (mdl_w.wen && mdl_w.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic mdl_reset();
        mdl_e = '0; mdl_m = '0; mdl_w = '0;
        sq_left = 0; mdl_bcnt = 0;
    endtask

    // One cycle: drive at negedge, check settled outputs, then advance the model
    task automatic step(input logic [31:0] inst, input bit redir, input bit hold, input bit do_chk);
        meta_t d;
        bit    flushing, lu, bub, ph, squashed;
        @(negedge clk);
        hif.dec_inst    = inst;
        hif.ex_redirect = redir;
        hif.ext_hold    = hold;
        #1;
        d        = decode(inst);
        flushing = (sq_left > 0);
        lu       = !flushing && !redir && mdl_e.ld && mdl_e.wen &&
                   ((mdl_e.rd == d.rs1 && d.u1) || (mdl_e.rd == d.rs2 && d.u2));
        squashed = !hold && (redir || flushing);
        bub      = !hold && (redir || flushing || lu);
        ph       = hold || lu;
        if (do_chk) begin
            chk("pc_hold",    hif.pc_hold,    ph);
            chk("e_bubble",   hif.e_bubble,   bub);
            chk("freeze",     hif.freeze,     hold);
            chk("fwd_a",      hif.fwd_a,      exp_fwd(mdl_e.rs1, mdl_e.u1));
            chk("fwd_b",      hif.fwd_b,      exp_fwd(mdl_e.rs2, mdl_e.u2));
            chk("dfwd_a",     hif.dfwd_a,     mdl_w.wen && mdl_w.rd == d.rs1 && d.u1 && !squashed);
            chk("dfwd_b",     hif.dfwd_b,     mdl_w.wen && mdl_w.rd == d.rs2 && d.u2 && !squashed);
            chk("bubble_cnt", hif.bubble_cnt, mdl_bcnt);
        end
        if (!hold) begin
            if (redir) sq_left = FC - 1;
            else if (sq_left > 0) sq_left--;
            mdl_w = mdl_m;
            mdl_m = mdl_e;
            mdl_e = bub ? '0 : d;
            if (bub && mdl_bcnt < 32'hFFFF) mdl_bcnt++;
        end
    endtask

    initial begin
        int unsigned b0;
        logic [6:0]  ops [10];
        logic [31:0] ri;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JR, OP_JAL, OP_LUI, OP_AUI, OP_SYS};

        hif.dec_inst = '0; hif.ex_redirect = 1'b0; hif.ext_hold = 1'b0;
        mdl_reset();
        #2;
        chk("rst_pc_hold",  hif.pc_hold,    0);
        chk("rst_e_bubble", hif.e_bubble,   0);
        chk("rst_fwd_a",    hif.fwd_a,      0);
        chk("rst_fwd_b",    hif.fwd_b,      0);
        chk("rst_dfwd_a",   hif.dfwd_a,     0);
        chk("rst_bcnt",     hif.bubble_cnt, 0);
        hif.ext_hold = 1'b1;
        #1;
        chk("rst_freeze",   hif.freeze,     1);
        hif.ext_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ALU-ALU forwarding from M on both operands
        step(mk(OP_R, 5'd1, 5'd2, 5'd3), 0, 0, 1);
        step(mk(OP_R, 5'd4, 5'd1, 5'd1), 0, 0, 1);
        chk("tp1_no_stall", hif.pc_hold, 0);
        step(NOP, 0, 0, 1);
        chk("tp1_fwd_a", hif.fwd_a, 2'b01);
        chk("tp1_fwd_b", hif.fwd_b, 2'b01);

        // Load-use: one stall then W forwarding
        b0 = mdl_bcnt;
        step(mk(OP_LD, 5'd5, 5'd0, 5'd0), 0, 0, 1);
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 0, 1);
        chk("tp2_pc_hold", hif.pc_hold, 1);
        chk("tp2_bubble",  hif.e_bubble, 1);
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 0, 1);
        chk("tp2_released", hif.pc_hold, 0);
        step(NOP, 0, 0, 1);
        chk("tp2_fwd_a", hif.fwd_a, 2'b10);
        chk("tp2_bcnt",  hif.bubble_cnt, b0 + 1);

        // x0 destination never stalls; W bypass into D
        step(mk(OP_LD, 5'd0, 5'd0, 5'd0), 0, 0, 1);
        step(mk(OP_R, 5'd6, 5'd0, 5'd0), 0, 0, 1);
        chk("tp3_no_stall", hif.pc_hold, 0);
        step(mk(OP_R, 5'd7, 5'd1, 5'd2), 0, 0, 1);
        chk("tp3_fwd0", hif.fwd_a, 2'b00);
        step(NOP, 0, 0, 1);
        step(NOP, 0, 0, 1);
        step(mk(OP_R, 5'd8, 5'd7, 5'd0), 0, 0, 1);
        chk("tp3_dfwd_a", hif.dfwd_a, 1);

        // Redirect window with a load-use pair colliding with the redirect
        b0 = mdl_bcnt;
        step(mk(OP_LD, 5'd5, 5'd0, 5'd0), 0, 0, 1);
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 1, 0, 1);
        chk("tp4_redir_no_hold", hif.pc_hold, 0);
        chk("tp4_bub0", hif.e_bubble, 1);
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 0, 1);
        chk("tp4_bub1", hif.e_bubble, 1);
        step(NOP, 0, 0, 1);
        chk("tp4_bub2", hif.e_bubble, 1);
        step(NOP, 0, 0, 1);
        chk("tp4_bub_end", hif.e_bubble, 0);
        chk("tp4_bcnt", hif.bubble_cnt, b0 + 3);

        // Freeze during the load-use cycle
        step(mk(OP_LD, 5'd5, 5'd0, 5'd0), 0, 0, 1);
        repeat (4) begin
            step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 1, 1);
            chk("tp5_frz_hold", hif.pc_hold, 1);
            chk("tp5_frz_bub",  hif.e_bubble, 0);
        end
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 0, 1);
        chk("tp5_stall", hif.e_bubble, 1);
        step(mk(OP_R, 5'd6, 5'd5, 5'd0), 0, 0, 1);
        chk("tp5_one_bubble", hif.e_bubble, 0);
        step(NOP, 0, 0, 1);
        chk("tp5_fwd_a", hif.fwd_a, 2'b10);

        // Random traffic on a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            ri = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step(ri, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 1);
        end

        // Asynchronous reset in the middle of a flush
        step(NOP, 1, 0, 1);
        step(NOP, 0, 0, 1);
        @(negedge clk);
        hif.ex_redirect = 1'b0; hif.ext_hold = 1'b0; hif.dec_inst = NOP;
        rst = 1'b0;
        #1;
        mdl_reset();
        chk("mid_rst_bubble", hif.e_bubble, 0);
        chk("mid_rst_bcnt",   hif.bubble_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        step(NOP, 0, 0, 1);
        chk("post_rst_run", hif.e_bubble, 0);

        // Saturation of the bubble counter
        for (int i = 0; i < 65540; i++) step(NOP, 1, 0, 0);
        step(NOP, 1, 0, 1);
        chk("sat_bcnt", hif.bubble_cnt, 16'hFFFF);
        step(NOP, 0, 0, 1);
        chk("sat_hold", hif.bubble_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
